// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU op codes, forwarding selects, EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_NE  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_LT  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_GE  = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b1100;

    // Source of an ALU operand in EX: register-file copy, EX/MEM result or MEM/WB result.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

    // Control word of a bubble: nothing is written, ALU does a harmless ADD.
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

endpackage

// File: rtl/forward_unit.sv
// Picks the operand source for rs1/rs2 in EX from the EX/MEM and MEM/WB writers.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
import riscv_pkg::*;

module forward_unit #(
    parameter int REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] rs1,
    input  logic [REG_ADDR-1:0] rs2,
    input  logic                exm_reg_write,
    input  logic [REG_ADDR-1:0] exm_rd,
    input  logic                mwb_reg_write,
    input  logic [REG_ADDR-1:0] mwb_rd,
    output fwd_sel_e            fwd_a,
    output fwd_sel_e            fwd_b
);

    logic exm_hit_a;
    logic exm_hit_b;
    logic mwb_hit_a;
    logic mwb_hit_b;

    // Match each operand against both writers; x0 is never a forwarding target.
    always_comb begin
        exm_hit_a = exm_reg_write && (exm_rd != '0) && (exm_rd == rs1);
        exm_hit_b = exm_reg_write && (exm_rd != '0) && (exm_rd == rs2);
        mwb_hit_a = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs1);
        mwb_hit_b = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs2);
    end

    // The younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (exm_hit_a) begin
            fwd_a = FWD_EXM;
        end else if (mwb_hit_a) begin
            fwd_a = FWD_MWB;
        end
        if (exm_hit_b) begin
            fwd_b = FWD_EXM;
        end else if (mwb_hit_b) begin
            fwd_b = FWD_MWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall generation.
// Latency: one cycle ID -> ex_*/Operation; SrcA/SrcB follow forwarding inputs combinationally.
// Backpressure: ex_stall holds every register; id_stall asks decode/fetch to hold for one bubble.
import riscv_pkg::*;

module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_mem_to_reg,
    input  logic                     exm_reg_write,
    input  logic [REG_ADDR-1:0]      exm_rd,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic                     mwb_reg_write,
    input  logic [REG_ADDR-1:0]      mwb_rd,
    input  logic [DATA_WIDTH-1:0]    mwb_result,
    input  logic                     flush,
    input  logic                     ex_stall,
    output logic                     id_stall,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_mem_to_reg,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_store_data
);

    logic                  valid_q,    valid_d;
    ex_ctrl_t              ctrl_q,     ctrl_d;
    logic [REG_ADDR-1:0]   rd_q,       rd_d;
    logic [REG_ADDR-1:0]   rs1_q,      rs1_d;
    logic [REG_ADDR-1:0]   rs2_q,      rs2_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0] imm_q,      imm_d;
    logic [DATA_WIDTH-1:0] pc_q,       pc_d;

    logic                  load_use;
    logic [DATA_WIDTH-1:0] rs1_cap;
    logic [DATA_WIDTH-1:0] rs2_cap;
    ex_ctrl_t              id_ctrl;
    fwd_sel_e              fwd_a;
    fwd_sel_e              fwd_b;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // Load in EX whose destination is read by the instruction in ID; a flush kills the consumer anyway.
    always_comb begin
        load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                   ((rd_q == id_rs1) || (rd_q == id_rs2));
        id_stall = load_use && !flush;
    end

    // Capture-time bypass: a value written back this very cycle is not yet visible in the register file read.
    always_comb begin
        rs1_cap = id_rs1_data;
        rs2_cap = id_rs2_data;
        if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rs1)) begin
            rs1_cap = mwb_result;
        end
        if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rs2)) begin
            rs2_cap = mwb_result;
        end
        id_ctrl = '{
            reg_write:  id_reg_write,
            mem_read:   id_mem_read,
            mem_write:  id_mem_write,
            mem_to_reg: id_mem_to_reg,
            alu_src:    id_alu_src,
            alu_op:     ALU_OP_W'(id_alu_op)
        };
    end

    // Next register contents: hold on ex_stall, bubble on flush/stall/empty slot, else capture ID.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        if (!ex_stall) begin
            if (flush || id_stall || !id_valid) begin
                valid_d    = 1'b0;
                ctrl_d     = EX_CTRL_BUBBLE;
                rd_d       = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                pc_d       = '0;
            end else begin
                valid_d    = 1'b1;
                ctrl_d     = id_ctrl;
                rd_d       = id_rd;
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rs1_data_d = rs1_cap;
                rs2_data_d = rs2_cap;
                imm_d      = id_imm;
                pc_d       = id_pc;
            end
        end
    end

    // Stage registers; reset clears to a bubble asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= EX_CTRL_BUBBLE;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
        end
    end

    forward_unit #(
        .REG_ADDR (REG_ADDR)
    ) u_forward_unit (
        .rs1           (rs1_q),
        .rs2           (rs2_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Operand muxes driven by the forward unit's selects.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        case (fwd_a)
            FWD_EXM: fwd_rs1 = exm_result;
            FWD_MWB: fwd_rs1 = mwb_result;
            default: fwd_rs1 = rs1_data_q;
        endcase
        case (fwd_b)
            FWD_EXM: fwd_rs2 = exm_result;
            FWD_MWB: fwd_rs2 = mwb_result;
            default: fwd_rs2 = rs2_data_q;
        endcase
    end

    // ALU operands and register-sourced outputs.
    always_comb begin
        SrcA          = fwd_rs1;
        SrcB          = ctrl_q.alu_src ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        Operation     = OPCODE_LENGTH'(ctrl_q.alu_op);
        ex_valid      = valid_q;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_mem_to_reg = ctrl_q.mem_to_reg;
        ex_rd         = rd_q;
        ex_pc         = pc_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, bypass, flush/stall, async reset.
// Latency: checks registered outputs #1 after the capturing edge, combinational ones #1 after input change.
// Backpressure: exercises ex_stall hold and id_stall bubble insertion.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        flush, ex_stall;
    logic        id_stall;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_store_data;

    int vectors = 0;
    int miscompares = 0;

    id_ex_stage #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4),
        .REG_ADDR      (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .id_stall      (id_stall),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .Operation     (Operation),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rd         (ex_rd),
        .ex_pc         (ex_pc),
        .ex_store_data (ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_alu_op = 4'b0010; id_alu_src = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
        flush = 0; ex_stall = 0;
    endtask

    initial begin
        clear_inputs();
        // Reset with random inputs
        #2 reset_n = 0;
        id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        id_alu_op = 4'($urandom); id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
        id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
        exm_reg_write = 1'($urandom); exm_rd = 5'($urandom); exm_result = $urandom;
        mwb_reg_write = 1'($urandom); mwb_rd = 5'($urandom); mwb_result = $urandom;
        flush = 1'($urandom); ex_stall = 1'($urandom);
        tick();
        tick();
        chk("rst_id_stall", id_stall, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_operation", Operation, 32'h2);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_store_data", ex_store_data, 0);
        clear_inputs();
        reset_n = 1;

        // ADDI x5,x0,7
        id_valid = 1; id_rs1 = 0; id_rd = 5; id_imm = 7; id_alu_src = 1; id_reg_write = 1;
        id_pc = 32'h100;
        tick();
        chk("addi_srca", SrcA, 0);
        chk("addi_srcb", SrcB, 7);
        chk("addi_rd", ex_rd, 5);
        chk("addi_reg_write", ex_reg_write, 1);
        chk("addi_valid", ex_valid, 1);
        chk("addi_pc", ex_pc, 32'h100);

        // SUB x7,x3,x0 with x3=0x33 from the register file
        clear_inputs();
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h33; id_rd = 7; id_alu_op = 4'b0101;
        id_reg_write = 1;
        tick();
        chk("sub_operation", Operation, 32'h5);
        chk("sub_srca_reg", SrcA, 32'h33);
        id_valid = 0;
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'h22;
        #1 chk("fwd_exm_priority", SrcA, 32'h11);
        exm_reg_write = 0;
        #1 chk("fwd_mwb", SrcA, 32'h22);
        exm_reg_write = 1; exm_rd = 0; mwb_rd = 0;
        #1 chk("fwd_x0_none", SrcA, 32'h33);
        chk("fwd_srcb_reg", SrcB, 0);

        // LW x4, 8(x1)
        clear_inputs();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 32'h1000; id_imm = 8; id_alu_src = 1;
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_rd = 4;
        tick();
        chk("lw_mem_read", ex_mem_read, 1);
        chk("lw_srca", SrcA, 32'h1000);
        chk("lw_srcb", SrcB, 8);
        // ADD x6,x4,x1 depends on the load
        clear_inputs();
        id_valid = 1; id_rs1 = 4; id_rs2 = 1; id_rd = 6; id_rs2_data = 5; id_reg_write = 1;
        #1 chk("lu_id_stall", id_stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_stall_drops", id_stall, 0);
        exm_reg_write = 1; exm_rd = 4; exm_result = 32'hAB;
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 1; mwb_rd = 4; mwb_result = 32'hAB;
        #1 chk("lu_srca_mwb", SrcA, 32'hAB);
        chk("lu_srcb_reg", SrcB, 5);

        // SW x2, 4(x0) while x2=0xDEAD is written back the same cycle
        clear_inputs();
        id_valid = 1; id_rs2 = 2; id_rs2_data = 0; id_imm = 4; id_alu_src = 1; id_mem_write = 1;
        mwb_reg_write = 1; mwb_rd = 2; mwb_result = 32'hDEAD;
        tick();
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
        #1 chk("byp_store_data", ex_store_data, 32'hDEAD);
        chk("byp_mem_write", ex_mem_write, 1);
        chk("byp_srcb_imm", SrcB, 4);

        // LW x9 then a dependent instruction under flush
        clear_inputs();
        id_valid = 1; id_rd = 9; id_mem_read = 1; id_reg_write = 1; id_alu_src = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_rs1 = 9; id_rd = 10; id_reg_write = 1; id_pc = 32'h44;
        #1 chk("lu_no_flush_stall", id_stall, 1);
        flush = 1;
        #1 chk("flush_masks_stall", id_stall, 0);
        tick();
        chk("flush_bubble_valid", ex_valid, 0);
        chk("flush_bubble_ctrl", {ex_reg_write, ex_mem_read}, 0);
        chk("flush_bubble_op", Operation, 32'h2);
        chk("flush_bubble_pc", ex_pc, 0);

        // XOR x11 at 0x200, then hold with ex_stall while flush is asserted
        clear_inputs();
        id_valid = 1; id_rd = 11; id_reg_write = 1; id_alu_op = 4'b1100; id_pc = 32'h200;
        tick();
        chk("xor_rd", ex_rd, 11);
        ex_stall = 1; flush = 1;
        id_rd = 12; id_pc = 32'h300; id_alu_op = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", ex_valid, 1);
            chk("hold_rd", ex_rd, 11);
            chk("hold_op", Operation, 32'hC);
            chk("hold_pc", ex_pc, 32'h200);
        end

        // Asynchronous reset between edges while stalled
        #2 reset_n = 0;
        #1 chk("arst_valid", ex_valid, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_op", Operation, 32'h2);
        chk("arst_pc", ex_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
